// File: rtl/boreal_vec_pkg.sv
// Shared definitions for the boreal vector unit: lane opcodes (also decoded by
// boreal_vec_lane) and the sequencer state encoding.
package boreal_vec_pkg;

  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_MAC      = 3'd1;
  localparam logic [2:0] OP_SCALE    = 3'd2;
  localparam logic [2:0] OP_CLAMP    = 3'd3;
  localparam logic [2:0] OP_LOAD_ACC = 3'd4;
  localparam logic [2:0] OP_ZERO_ACC = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ZERO  = 3'd1,
    ST_MAC   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_SCALE = 3'd4,
    ST_CLAMP = 3'd5,
    ST_WB    = 3'd6
  } seq_state_e;

  // First step after accumulation; disabled post-steps cost zero cycles.
  function automatic seq_state_e post_mac_state(input logic do_scale, input logic do_clamp);
    if (do_scale) return ST_SCALE;
    else if (do_clamp) return ST_CLAMP;
    else return ST_WB;
  endfunction

endpackage

// File: rtl/boreal_vec_seq.sv
// Sequencer for the boreal_vec_lane SIMD array: turns one latched job descriptor
// into the broadcast lane control stream, operand reads and a writeback handshake.
module boreal_vec_seq
  import boreal_vec_pkg::*;
#(
  parameter int AW = 12,
  parameter int LW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [LW-1:0] cfg_len,
  input  logic [AW-1:0] cfg_src_base,
  input  logic [AW-1:0] cfg_dst_addr,
  input  logic          cfg_do_scale,
  input  logic          cfg_do_clamp,
  input  logic          abort,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          lane_en,
  output logic [2:0]    lane_op,
  output logic          wr_valid,
  output logic [AW-1:0] wr_addr,
  input  logic          wr_ready,
  output logic          busy,
  output logic          done,
  output logic [15:0]   stat_cycles
);

  seq_state_e    state_q, state_d;
  logic [LW-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [AW-1:0] src_q, src_d, dst_q, dst_d, rd_addr_q, rd_addr_d;
  logic          scale_q, scale_d, clamp_q, clamp_d;
  logic          rd_en_q, rd_en_d, lane_en_q, lane_en_d;
  logic [2:0]    lane_op_q, lane_op_d;
  logic          wr_valid_q, wr_valid_d, done_q, done_d;
  logic [15:0]   run_q, run_d, stat_q, stat_d;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    src_d      = src_q;
    dst_d      = dst_q;
    scale_d    = scale_q;
    clamp_d    = clamp_q;
    cnt_d      = cnt_q;
    rd_addr_d  = rd_addr_q;
    rd_en_d    = 1'b0;
    lane_en_d  = 1'b0;
    lane_op_d  = OP_NOP;
    wr_valid_d = 1'b0;
    done_d     = 1'b0;
    run_d      = run_q;
    stat_d     = stat_q;

    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
    end else begin
      if (state_q != ST_IDLE) run_d = sat_add(run_q, 2'd1);

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_d   = cfg_len;
            src_d   = cfg_src_base;
            dst_d   = cfg_dst_addr;
            scale_d = cfg_do_scale;
            clamp_d = cfg_do_clamp;
            run_d   = 16'd1;
            state_d = ST_ZERO;
          end
        end
        ST_ZERO: begin
          if (len_q != '0) begin
            state_d   = ST_MAC;
            rd_addr_d = src_q;
            cnt_d     = LW'(1);
          end else begin
            state_d = post_mac_state(scale_q, clamp_q);
          end
        end
        ST_MAC: begin
          if (cnt_q == len_q) begin
            state_d = ST_DRAIN;
          end else begin
            cnt_d     = cnt_q + LW'(1);
            rd_addr_d = rd_addr_q + AW'(1);
          end
        end
        ST_DRAIN: state_d = post_mac_state(scale_q, clamp_q);
        ST_SCALE: state_d = clamp_q ? ST_CLAMP : ST_WB;
        ST_CLAMP: state_d = ST_WB;
        ST_WB: begin
          if (wr_ready) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            // Count the handshake cycle and the done cycle itself.
            stat_d  = sat_add(run_q, 2'd2);
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // MAC enable trails its operand read by one cycle so data and enable meet at the lanes.
      lane_en_d = rd_en_q;
      lane_op_d = rd_en_q ? OP_MAC : OP_NOP;

      case (state_d)
        ST_ZERO: begin
          lane_en_d = 1'b1;
          lane_op_d = OP_ZERO_ACC;
        end
        ST_MAC: rd_en_d = 1'b1;
        ST_SCALE: begin
          lane_en_d = 1'b1;
          lane_op_d = OP_SCALE;
        end
        ST_CLAMP: begin
          lane_en_d = 1'b1;
          lane_op_d = OP_CLAMP;
        end
        ST_WB: wr_valid_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rd_addr_q  <= '0;
      dst_q      <= '0;
      rd_en_q    <= 1'b0;
      lane_en_q  <= 1'b0;
      lane_op_q  <= OP_NOP;
      wr_valid_q <= 1'b0;
      done_q     <= 1'b0;
      run_q      <= '0;
      stat_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_addr_q  <= rd_addr_d;
      dst_q      <= dst_d;
      rd_en_q    <= rd_en_d;
      lane_en_q  <= lane_en_d;
      lane_op_q  <= lane_op_d;
      wr_valid_q <= wr_valid_d;
      done_q     <= done_d;
      run_q      <= run_d;
      stat_q     <= stat_d;
    end
  end

  // Descriptor fields are only meaningful once a job has been accepted.
  always_ff @(posedge clk) begin
    len_q   <= len_d;
    src_q   <= src_d;
    scale_q <= scale_d;
    clamp_q <= clamp_d;
  end

  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign lane_en     = lane_en_q;
  assign lane_op     = lane_op_q;
  assign wr_valid    = wr_valid_q;
  assign wr_addr     = dst_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign stat_cycles = stat_q;

endmodule

// File: tb/tb_boreal_vec_seq.sv
// Scoreboard bench for boreal_vec_seq: a job-level timeline model queues the
// expected reads, lane ops, writeback and done events; a monitor pops and compares.
module tb_boreal_vec_seq;
  import boreal_vec_pkg::*;

  localparam int AW = 12;
  localparam int LW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic [AW-1:0] cfg_src_base = '0;
  logic [AW-1:0] cfg_dst_addr = '0;
  logic          cfg_do_scale = 1'b0;
  logic          cfg_do_clamp = 1'b0;
  logic          abort = 1'b0;
  logic          wr_ready = 1'b0;
  logic          rd_en, lane_en, wr_valid, busy, done;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [2:0]    lane_op;
  logic [15:0]   stat_cycles;

  boreal_vec_seq #(.AW(AW), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len),
    .cfg_src_base(cfg_src_base), .cfg_dst_addr(cfg_dst_addr),
    .cfg_do_scale(cfg_do_scale), .cfg_do_clamp(cfg_do_clamp), .abort(abort),
    .rd_en(rd_en), .rd_addr(rd_addr), .lane_en(lane_en), .lane_op(lane_op),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_ready(wr_ready), .busy(busy),
    .done(done), .stat_cycles(stat_cycles)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int val; } ev_t;
  typedef struct { int wv; int h; int addr; bit abrt; } wr_t;

  ev_t rdq[$];
  ev_t laneq[$];
  wr_t wrq[$];
  ev_t doneq[$];

  int n_chk = 0;
  int n_pass = 0;
  int last_stat = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
  endtask

  // Timeline of one job accepted at cycle a, straight from the job rules.
  task automatic push_job(input int a, input int n, input int base, input int dst,
                          input bit s, input bit c, input int stall, input bit abrt,
                          output int wv, output int h);
    int t;
    laneq.push_back('{a + 1, int'(OP_ZERO_ACC)});
    for (int k = 0; k < n; k++) begin
      rdq.push_back('{a + 2 + k, (base + k) % (1 << AW)});
      laneq.push_back('{a + 3 + k, int'(OP_MAC)});
    end
    t = (n > 0) ? a + n + 3 : a + 2;
    if (s) begin laneq.push_back('{t, int'(OP_SCALE)}); t++; end
    if (c) begin laneq.push_back('{t, int'(OP_CLAMP)}); t++; end
    wv = t;
    h  = abrt ? wv : wv + stall;
    wrq.push_back('{wv, h, dst, abrt});
    if (!abrt) doneq.push_back('{h + 1, (h + 1) - a + 1});
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive_cfg(input int n, input int base, input int dst, input bit s, input bit c);
    cfg_len = LW'(n); cfg_src_base = AW'(base); cfg_dst_addr = AW'(dst);
    cfg_do_scale = s; cfg_do_clamp = c;
  endtask

  task automatic scramble_cfg();
    cfg_len = LW'($urandom); cfg_src_base = AW'($urandom); cfg_dst_addr = AW'($urandom);
    cfg_do_scale = 1'($urandom_range(0, 1)); cfg_do_clamp = 1'($urandom_range(0, 1));
  endtask

  task automatic run_job(input int n, input int base, input int dst, input bit s,
                         input bit c, input int stall);
    int a, wv, h;
    a = cyc;
    drive_cfg(n, base, dst, s, c);
    start = 1'b1; abort = 1'b0;
    push_job(a, n, base, dst, s, c, stall, 1'b0, wv, h);
    step();
    while (cyc <= h) begin
      start = 1'($urandom_range(0, 3) == 0);
      scramble_cfg();
      wr_ready = (cyc == h) || (cyc < wv && $urandom_range(0, 1) == 1);
      step();
    end
    start = 1'b0; wr_ready = 1'b0;
    last_stat = (h + 1) - a + 1;
  endtask

  task automatic run_abort_mac(input int n, input int off);
    int a, base;
    a = cyc; base = $urandom_range(0, (1 << AW) - 1);
    drive_cfg(n, base, $urandom_range(0, 4095), 1'b1, 1'b1);
    start = 1'b1;
    laneq.push_back('{a + 1, int'(OP_ZERO_ACC)});
    for (int k = 0; k <= off - 2; k++) rdq.push_back('{a + 2 + k, (base + k) % (1 << AW)});
    for (int k = 0; k <= off - 3; k++) laneq.push_back('{a + 3 + k, int'(OP_MAC)});
    step();
    start = 1'b0;
    while (cyc < a + off) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_rd_en", int'(rd_en), 0);
    chk("abort_lane_en", int'(lane_en), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_stat", int'(stat_cycles), last_stat);
    repeat (4) step();
  endtask

  task automatic run_abort_wb(input int n, input bit s, input bit c);
    int a, wv, h, dst;
    a = cyc; dst = $urandom_range(0, 4095);
    drive_cfg(n, $urandom_range(0, 4095), dst, s, c);
    start = 1'b1;
    push_job(a, n, int'(cfg_src_base), dst, s, c, 0, 1'b1, wv, h);
    step();
    start = 1'b0;
    while (cyc < wv) step();
    abort = 1'b1; wr_ready = 1'b1;
    step();
    abort = 1'b0; wr_ready = 1'b0;
    chk("abortwb_wr_valid", int'(wr_valid), 0);
    chk("abortwb_busy", int'(busy), 0);
    chk("abortwb_done", int'(done), 0);
    chk("abortwb_stat", int'(stat_cycles), last_stat);
    repeat (3) step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, int'(rd_en), 0);
    chk({tag, "_rd_addr"}, int'(rd_addr), 0);
    chk({tag, "_lane_en"}, int'(lane_en), 0);
    chk({tag, "_lane_op"}, int'(lane_op), int'(OP_NOP));
    chk({tag, "_wr_valid"}, int'(wr_valid), 0);
    chk({tag, "_wr_addr"}, int'(wr_addr), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_stat"}, int'(stat_cycles), 0);
  endtask

  // Monitor: every DUT-presented event must match the head of its queue.
  initial begin
    bit wv_prev;
    ev_t e;
    wr_t w;
    wv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wv_prev = 1'b0;
      end else begin
        if (rd_en) begin
          if (rdq.size() == 0) chk("rd_unexpected", int'(rd_addr), -1);
          else begin
            e = rdq.pop_front();
            chk("rd_cycle", cyc, e.cyc);
            chk("rd_addr", int'(rd_addr), e.val);
          end
        end
        if (lane_en) begin
          if (laneq.size() == 0) chk("lane_unexpected", int'(lane_op), -1);
          else begin
            e = laneq.pop_front();
            chk("lane_cycle", cyc, e.cyc);
            chk("lane_op", int'(lane_op), e.val);
            if (e.val == int'(OP_ZERO_ACC)) chk("zero_busy", int'(busy), 1);
          end
        end
        if (wr_valid) begin
          if (wrq.size() == 0) chk("wr_unexpected", int'(wr_addr), -1);
          else begin
            if (!wv_prev) chk("wr_rise_cycle", cyc, wrq[0].wv);
            chk("wr_addr", int'(wr_addr), wrq[0].addr);
            if (wr_ready || abort) begin
              w = wrq.pop_front();
              chk("wr_abort", int'(abort), int'(w.abrt));
              if (!abort) chk("wr_hs_cycle", cyc, w.h);
            end
          end
        end
        wv_prev = wr_valid;
        if (done) begin
          if (doneq.size() == 0) chk("done_unexpected", int'(stat_cycles), -1);
          else begin
            e = doneq.pop_front();
            chk("done_cycle", cyc, e.cyc);
            chk("done_stat", int'(stat_cycles), e.val);
            chk("done_busy", int'(busy), 0);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    #1 rst_n = 1'b0;
    #10;
    chk_all_zero("reset");
    @(negedge clk); #2 rst_n = 1'b1;
    step();

    run_job(4, 'h010, 'h123, 1'b1, 1'b1, 0);
    chk("job1_stat", int'(stat_cycles), 11);
    run_job(0, 'h200, 'h0AB, 1'b0, 1'b0, 0);
    chk("job0_stat", int'(stat_cycles), 4);
    run_job(3, 'hFFE, 'h777, 1'b0, 1'b1, 0);
    run_job(2, 'h040, 'h555, 1'b1, 1'b0, 5);
    run_job(1, 'h300, 'h666, 1'b0, 1'b0, 0);
    run_job(0, 'h000, 'hFFF, 1'b1, 1'b0, 1);
    step();

    run_abort_mac(8, 3);
    run_abort_wb(2, 1'b1, 1'b0);
    run_abort_mac(5, $urandom_range(2, 6));

    for (int j = 0; j < 40; j++) begin
      int n, g;
      n = ($urandom_range(0, 9) == 0) ? $urandom_range(40, 150) : $urandom_range(0, 12);
      run_job(n, $urandom_range(0, 4095), $urandom_range(0, 4095),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 4));
      g = $urandom_range(0, 2);
      for (int i = 0; i < g; i++) begin
        abort = 1'($urandom_range(0, 1));
        scramble_cfg();
        step();
      end
      abort = 1'b0;
    end

    // Asynchronous reset in the middle of the MAC phase.
    a = cyc;
    drive_cfg(6, 'h100, 'h222, 1'b1, 1'b1);
    start = 1'b1;
    laneq.push_back('{a + 1, int'(OP_ZERO_ACC)});
    rdq.push_back('{a + 2, 'h100});
    rdq.push_back('{a + 3, 'h101});
    laneq.push_back('{a + 3, int'(OP_MAC)});
    step();
    start = 1'b0;
    while (cyc < a + 4) step();
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    step(); step();
    @(negedge clk); #2 rst_n = 1'b1;
    step();
    last_stat = 0;
    run_job(1, 'h0FF, 'h3C3, 1'b1, 1'b1, 2);

    repeat (5) step();
    chk("rdq_empty", rdq.size(), 0);
    chk("laneq_empty", laneq.size(), 0);
    chk("wrq_empty", wrq.size(), 0);
    chk("doneq_empty", doneq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
